// File: rtl/binary_decoder_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready flow control and a 2-entry skid buffer.
// Optional saturating range-error counter built only when BINARY_DECODER_ERRCNT_EN is defined.
module binary_decoder_pipe #(
    parameter int  p_WIDTH      = 5,
    parameter int  p_CNT_WIDTH  = 8,
    localparam int p_ADDR_WIDTH = $clog2(p_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_enable,
    input  logic [p_ADDR_WIDTH-1:0] iv_addr,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [p_WIDTH-1:0]      ov_onehot,
    output logic                    o_range_err,
    input  logic                    i_err_clr,
    output logic [p_CNT_WIDTH-1:0]  ov_err_count
);

    localparam logic [p_ADDR_WIDTH:0] lp_WIDTH_CMP = (p_ADDR_WIDTH + 1)'(p_WIDTH);

    logic                 r_ready;
    logic                 r_main_valid;
    logic [p_WIDTH-1:0]   r_main_onehot;
    logic                 r_main_err;
    logic                 r_skid_valid;
    logic [p_WIDTH-1:0]   r_skid_onehot;
    logic                 r_skid_err;

    logic                 w_accept;
    logic                 w_main_free;
    logic                 w_skid_next;
    logic [p_WIDTH-1:0]   w_dec_onehot;
    logic                 w_dec_err;

    // Decode of the beat currently presented; captured only on accept.
    always_comb begin
        w_dec_onehot = '0;
        for (int i = 0; i < p_WIDTH; i++) begin
            if (i_enable && (iv_addr == p_ADDR_WIDTH'(i))) begin
                w_dec_onehot[i] = 1'b1;
            end
        end
    end

    assign w_dec_err   = i_enable && ({1'b0, iv_addr} >= lp_WIDTH_CMP);
    assign w_accept    = i_valid && r_ready;
    assign w_main_free = !r_main_valid || i_ready;

    always_comb begin
        w_skid_next = r_skid_valid;
        if (r_skid_valid) begin
            w_skid_next = !w_main_free;
        end else if (w_accept && !w_main_free) begin
            w_skid_next = 1'b1;
        end
    end

    // Ready drops as soon as the skid fills and returns one edge after it empties.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= !w_skid_next && !r_skid_valid;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_main_valid  <= 1'b0;
            r_main_onehot <= '0;
            r_main_err    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_onehot <= '0;
            r_skid_err    <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid  <= 1'b1;
                r_main_onehot <= r_skid_onehot;
                r_main_err    <= r_skid_err;
                r_skid_valid  <= 1'b0;
                r_skid_onehot <= '0;
                r_skid_err    <= 1'b0;
            end else if (w_accept) begin
                r_main_valid  <= 1'b1;
                r_main_onehot <= w_dec_onehot;
                r_main_err    <= w_dec_err;
            end else begin
                // Empty main register presents all-zero outputs.
                r_main_valid  <= 1'b0;
                r_main_onehot <= '0;
                r_main_err    <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_onehot <= w_dec_onehot;
            r_skid_err    <= w_dec_err;
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_main_valid;
    assign ov_onehot   = r_main_onehot;
    assign o_range_err = r_main_err;

`ifdef BINARY_DECODER_ERRCNT_EN
    logic [p_CNT_WIDTH-1:0] r_err_count;

    // Clear has priority over a same-cycle increment; count saturates at all-ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (i_err_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_dec_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign ov_err_count = r_err_count;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = i_err_clr;
    assign ov_err_count     = '0;
`endif

endmodule

// File: tb/tb_binary_decoder_pipe.sv
// Directed bench for binary_decoder_pipe (p_WIDTH=5, p_CNT_WIDTH=2): vector table plus
// hand-written backpressure, error-counter and reset sequences, with an in-order scoreboard.
module tb_binary_decoder_pipe;

    localparam int W  = 5;
    localparam int AW = 3;
    localparam int CW = 2;
`ifdef BINARY_DECODER_ERRCNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic          i_enable;
    logic [AW-1:0] iv_addr;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  ov_onehot;
    logic          o_range_err;
    logic          i_err_clr;
    logic [CW-1:0] ov_err_count;

    binary_decoder_pipe #(
        .p_WIDTH     (W),
        .p_CNT_WIDTH (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_enable     (i_enable),
        .iv_addr      (iv_addr),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .ov_onehot    (ov_onehot),
        .o_range_err  (o_range_err),
        .i_err_clr    (i_err_clr),
        .ov_err_count (ov_err_count)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q[$];
    logic [W:0] cur_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; an accept at this edge queues the expected beat.
    task automatic tick;
        if (i_valid && o_ready) exp_q.push_back(cur_exp);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic en, input logic [AW-1:0] a, input logic [W:0] exp);
        i_valid  = v;
        i_enable = en;
        iv_addr  = a;
        cur_exp  = exp;
    endtask

    // Scoreboard: every beat that leaves must match the oldest expected beat.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h, expected no beat", {o_range_err, ov_onehot});
            end else begin
                check("sb_beat", {26'd0, o_range_err, ov_onehot}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [W-1:0]  onehot;
        logic          err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 5'b00001, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 5'b00010, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 5'b00100, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 5'b01000, 1'b0};
        vecs[4]  = '{1'b1, 3'd4, 5'b10000, 1'b0};
        vecs[5]  = '{1'b0, 3'd3, 5'b00000, 1'b0};
        vecs[6]  = '{1'b1, 3'd5, 5'b00000, 1'b1};
        vecs[7]  = '{1'b1, 3'd6, 5'b00000, 1'b1};
        vecs[8]  = '{1'b1, 3'd7, 5'b00000, 1'b1};
        vecs[9]  = '{1'b0, 3'd7, 5'b00000, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 5'b00100, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 5'b00000, 1'b0};

        i_reset   = 1'b0;
        i_ready   = 1'b1;
        i_err_clr = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        #1;
        i_reset = 1'b1;
        repeat (3) tick;
        check("rst_ready",  o_ready, 0);
        check("rst_valid",  o_valid, 0);
        check("rst_onehot", ov_onehot, 0);
        check("rst_err",    o_range_err, 0);
        check("rst_count",  ov_err_count, 0);

        i_reset = 1'b0;
        #1;
        check("ready_before_edge", o_ready, 0);
        tick;
        check("ready_first_edge", o_ready, 1);

        // Streaming with i_ready=1: one-cycle latency, no gaps
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].en, vecs[i].addr, {vecs[i].err, vecs[i].onehot});
            tick;
            check($sformatf("vec%0d_valid", i),  o_valid, 1);
            check($sformatf("vec%0d_onehot", i), ov_onehot, vecs[i].onehot);
            check($sformatf("vec%0d_err", i),    o_range_err, vecs[i].err);
            check($sformatf("vec%0d_ready", i),  o_ready, 1);
        end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        check("idle_valid",  o_valid, 0);
        check("idle_onehot", ov_onehot, 0);
        check("count_after_table", ov_err_count, CNT_ON ? 3 : 0);

        // Clear wins over a same-cycle bad accept
        drive(1'b1, 1'b1, 3'd5, {1'b1, 5'b00000});
        i_err_clr = 1'b1;
        tick;
        i_err_clr = 1'b0;
        check("clr_err",   o_range_err, 1);
        check("clr_count", ov_err_count, 0);
        drive(1'b0, 1'b0, '0, '0);
        tick;

        // Saturation: five bad beats on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, AW'(5 + (i % 3)), {1'b1, 5'b00000});
            tick;
        end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        check("sat_count", ov_err_count, CNT_ON ? 3 : 0);

        // Backpressure: second beat parks in the skid, third is held off
        i_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd1, {1'b0, 5'b00010});
        tick;
        check("bp1_valid",  o_valid, 1);
        check("bp1_onehot", ov_onehot, 5'b00010);
        check("bp1_ready",  o_ready, 1);
        drive(1'b1, 1'b1, 3'd2, {1'b0, 5'b00100});
        tick;
        check("bp2_ready",  o_ready, 0);
        check("bp2_onehot", ov_onehot, 5'b00010);
        drive(1'b1, 1'b1, 3'd4, {1'b0, 5'b10000});
        tick;
        check("bp3_hold_onehot", ov_onehot, 5'b00010);
        check("bp3_hold_valid",  o_valid, 1);
        check("bp3_ready",       o_ready, 0);
        i_ready = 1'b1;
        tick;
        check("bp4_onehot", ov_onehot, 5'b00100);
        check("bp4_ready",  o_ready, 0);
        tick;
        check("bp5_valid",  o_valid, 0);
        check("bp5_onehot", ov_onehot, 0);
        check("bp5_ready",  o_ready, 1);
        tick;
        check("bp6_valid",  o_valid, 1);
        check("bp6_onehot", ov_onehot, 5'b10000);
        drive(1'b0, 1'b0, '0, '0);
        tick;
        check("bp7_valid", o_valid, 0);

        // Reset with both stages full discards everything at once
        i_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd3, {1'b0, 5'b01000});
        tick;
        drive(1'b1, 1'b1, 3'd0, {1'b0, 5'b00001});
        tick;
        check("full_ready", o_ready, 0);
        drive(1'b0, 1'b0, '0, '0);
        #1;
        i_reset = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_valid",  o_valid, 0);
        check("midrst_onehot", ov_onehot, 0);
        check("midrst_err",    o_range_err, 0);
        check("midrst_ready",  o_ready, 0);
        check("midrst_count",  ov_err_count, 0);
        i_ready = 1'b1;
        tick;
        i_reset = 1'b0;
        tick;
        check("postrst_ready", o_ready, 1);
        check("postrst_valid", o_valid, 0);
        repeat (2) tick;
        check("postrst_still_empty", o_valid, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
